// File: rtl/shift_pkg.sv
// shift_pkg: state encodings, default width and clog2 helper shared by the shift_tx8b/shift_reg8b serial link.
package shift_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
    localparam int DEF_WIDTH = 8;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) ;
        return r;
    endfunction
endpackage

// File: rtl/shift_tx_cnt.sv
// shift_tx_cnt: frame bit counter with clear, enable and terminal count (cnt == WIDTH-1).
module shift_tx_cnt
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = clog2(WIDTH);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + CW'(1);
    assign tc = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/shift_tx8b.sv
// shift_tx8b: valid/ready parallel-in, serial-out transmitter framed by sdout_en.
// Define SHIFT_TX_PARITY_EN to append one even-parity bit after the data.
module shift_tx8b
    import shift_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdout,
    output logic             sdout_en,
    output logic             tx_done,
    output logic             busy
);
    state_t state, nxt;
    logic [WIDTH-1:0] shreg;
    logic tc, last, accept, shifting, first, nb;
    assign first = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign nb = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shifting = state == ST_SHIFT && !tc;
    assign busy = state != ST_IDLE;
    assign tx_done = last;
    // Ready on the last frame bit too, so frames can run back to back.
    assign din_ready = !rst && (state == ST_IDLE || last);
    assign accept = din_valid && din_ready;
    shift_tx_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(accept),
        .en(shifting),
        .tc(tc)
    );
`ifdef SHIFT_TX_PARITY_EN
    logic par;
    assign last = state == ST_PARITY;
    // Running XOR of every data bit already placed on sdout.
    always_ff @(posedge clk or posedge rst)
        if (rst) par <= 1'b0;
        else if (accept) par <= first;
        else if (shifting) par <= par ^ nb;
`else
    assign last = state == ST_SHIFT && tc;
`endif
    always_comb begin
        nxt = state;
`ifdef SHIFT_TX_PARITY_EN
        if (state == ST_SHIFT && tc) nxt = ST_PARITY;
`endif
        if (last) nxt = ST_IDLE;
        if (accept) nxt = ST_SHIFT;
    end
    // The first bit goes straight to sdout at acceptance; shreg holds the rest.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            sdout    <= IDLE_LEVEL;
            sdout_en <= 1'b0;
        end else begin
            state    <= nxt;
            sdout_en <= nxt != ST_IDLE;
            if (accept) begin
                sdout <= first;
                shreg <= MSB_FIRST ? din << 1 : din >> 1;
            end else if (shifting) begin
                sdout <= nb;
                shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
            end
`ifdef SHIFT_TX_PARITY_EN
            else if (nxt == ST_PARITY) sdout <= par;
`endif
            else if (nxt == ST_IDLE) sdout <= IDLE_LEVEL;
        end
endmodule

// File: tb/tb_shift_tx8b.sv
// tb_shift_tx8b: scoreboard bench for shift_tx8b; expected bits queued at acceptance, checked per sdout_en cycle.
module tb_shift_tx8b;
    logic clk = 1'b0, rst = 1'b0, din_valid = 1'b0;
    logic [7:0] din = '0;
    logic din_ready, sdout, sdout_en, tx_done, busy;
    always #5 clk = ~clk;

    shift_tx8b dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .sdout(sdout),
        .sdout_en(sdout_en),
        .tx_done(tx_done),
        .busy(busy)
    );

`ifdef SHIFT_TX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    typedef struct {logic b; logic d;} exp_t;
    exp_t bq[$];
    logic [7:0] wq[$];
    int n_cmp = 0, n_err = 0, run = 0, last_run = 0, dones = 0, nbits = 0;
    logic [7:0] rx = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) bq.push_back('{b: w[7-i], d: (FL == 8 && i == 7)});
`ifdef SHIFT_TX_PARITY_EN
        bq.push_back('{b: ^w, d: 1'b1});
`endif
        wq.push_back(w);
    endtask

    task automatic send(input logic [7:0] w, input bit hold, input bit exp_done, output int waits);
        din = w;
        din_valid = 1'b1;
        waits = 0;
        while (!din_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check("accept_timeout", waits < 100, 1);
        check("done_at_accept", tx_done, exp_done);
        expect_word(w);
        @(posedge clk);
        #1;
        if (!hold) begin
            din_valid = 1'b0;
            din = 8'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || sdout_en) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 100, 1);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run = 0;
            nbits = 0;
            rx = '0;
        end else begin
            check("busy_vs_en", busy, sdout_en);
            if (sdout_en) begin
                run++;
                if (bq.size() == 0) check("bit_underflow", 1, 0);
                else begin
                    e = bq.pop_front();
                    check("sdout", sdout, e.b);
                    check("tx_done", tx_done, e.d);
                end
                if (nbits < 8) rx = {rx[6:0], sdout};
                nbits++;
                if (tx_done) begin
                    dones++;
                    nbits = 0;
                    if (wq.size() == 0) check("word_underflow", 1, 0);
                    else check("rx_word", rx, wq.pop_front());
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                check("idle_sdout", sdout, 0);
                check("idle_done", tx_done, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w, d0;
        #1 rst = 1'b1;
        #1;
        check("rst_sdout", sdout, 0);
        check("rst_en", sdout_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("ready_after_rst", din_ready, 1);

        d0 = dones;
        send(8'hA5, 0, 0, w);
        check("idle_wait", w, 0);
        drain();
        check("frame_len", last_run, FL);
        check("done_count", dones - d0, 1);

        d0 = dones;
        send(8'hA5, 1, 0, w);
        send(8'h3C, 0, 1, w);
        check("b2b_wait", w, FL);
        drain();
        check("b2b_len", last_run, 2 * FL);
        check("b2b_dones", dones - d0, 2);

        send(8'hC3, 0, 0, w);
        @(negedge clk);
        @(negedge clk);
        #1 din = 8'h55;
        din_valid = 1'b1;
        check("busy_ready", din_ready, 0);
        @(posedge clk);
        #1 din_valid = 1'b0;
        drain();
        check("busy_frame_len", last_run, FL);

        d0 = dones;
        send(8'hFF, 0, 0, w);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        bq.delete();
        wq.delete();
        #1;
        check("abort_en", sdout_en, 0);
        check("abort_busy", busy, 0);
        check("abort_sdout", sdout, 0);
        check("abort_done", tx_done, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("abort_ready", din_ready, 1);
        check("abort_no_done", dones - d0, 0);
        send(8'h81, 0, 0, w);
        drain();
        check("post_abort_len", last_run, FL);
        check("post_abort_dones", dones - d0, 1);

        d0 = dones;
        send(8'h07, 0, 0, w);
        drain();
        check("w07_len", last_run, FL);
        check("w07_dones", dones - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
